// File: rtl/dmem_arbiter_pkg.sv
// Shared types and widths for the data-memory arbiter: request payload,
// access width and response-owner encodings.
package dmem_arbiter_pkg;

    localparam int unsigned DMemAddrW       = 32;
    localparam int unsigned DMemDataW       = 32;
    localparam int unsigned StarveCntW      = 4;
    localparam int unsigned DMemStarveLimit = 4;

    typedef logic [DMemAddrW-1:0] dmem_addr_t;
    typedef logic [DMemDataW-1:0] dmem_data_t;

    typedef enum logic [1:0] {
        BYTE     = 2'd0,
        HALFWORD = 2'd1,
        WORD     = 2'd2
    } mem_width_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        CPU  = 2'd1,
        DMA  = 2'd2
    } dmem_owner_t;

    // One request as presented by either master, and as forwarded to memory.
    typedef struct packed {
        dmem_addr_t addr;
        mem_width_t width;
        logic       sign_extend;
        logic       we;
        dmem_data_t wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_starve_counter.sv
// Saturating wait counter with synchronous clear and a registered
// limit-reached flag, used to bound how long the DMA port can be held off.
module dmem_starve_counter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned Limit = DMemStarveLimit,
    parameter int unsigned CntW  = StarveCntW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inc,
    input  logic            clr,
    output logic [CntW-1:0] cnt,
    output logic            at_limit
);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;
    logic            at_limit_q;
    logic            at_limit_d;

    // Clear wins over increment; the count holds once it reaches the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CntW'(Limit))) begin
            cnt_d = cnt_q + CntW'(1);
        end
        at_limit_d = (cnt_d == CntW'(Limit));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            at_limit_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            at_limit_q <= at_limit_d;
        end
    end

    assign cnt      = cnt_q;
    assign at_limit = at_limit_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: CPU has priority,
// DMA is guaranteed a grant after StarveLimit waiting cycles.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned StarveLimit = DMemStarveLimit
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 cpu_valid,
    output logic                 cpu_ready,
    input  logic [DMemAddrW-1:0] cpu_addr,
    input  logic [1:0]           cpu_width,
    input  logic                 cpu_sign_extend,
    input  logic                 cpu_we,
    input  logic [DMemDataW-1:0] cpu_wdata,
    output logic                 cpu_rvalid,
    output logic [DMemDataW-1:0] cpu_rdata,

    input  logic                 dma_valid,
    output logic                 dma_ready,
    input  logic [DMemAddrW-1:0] dma_addr,
    input  logic [1:0]           dma_width,
    input  logic                 dma_sign_extend,
    input  logic                 dma_we,
    input  logic [DMemDataW-1:0] dma_wdata,
    output logic                 dma_rvalid,
    output logic [DMemDataW-1:0] dma_rdata,

    output logic [DMemAddrW-1:0] mem_addr,
    output logic [1:0]           mem_width,
    output logic                 mem_sign_extend,
    output logic                 mem_write_enable,
    output logic [DMemDataW-1:0] mem_data_in,
    input  logic [DMemDataW-1:0] mem_data_out
);

    dmem_req_t        cpu_req;
    dmem_req_t        dma_req;
    dmem_req_t        mem_req;
    logic             cpu_grant;
    logic             dma_grant;
    logic             starve_at_limit;
    logic [StarveCntW-1:0] starve_cnt;
    dmem_owner_t      resp_owner_q;
    dmem_owner_t      resp_owner_d;

    assign cpu_req = '{addr: cpu_addr, width: mem_width_t'(cpu_width),
                       sign_extend: cpu_sign_extend, we: cpu_we, wdata: cpu_wdata};
    assign dma_req = '{addr: dma_addr, width: mem_width_t'(dma_width),
                       sign_extend: dma_sign_extend, we: dma_we, wdata: dma_wdata};

    // Grant is combinational from valids and the registered starvation flag;
    // nothing is granted while reset is held.
    always_comb begin
        dma_grant = 1'b0;
        cpu_grant = 1'b0;
        if (!reset) begin
            dma_grant = dma_valid && (!cpu_valid || starve_at_limit);
            cpu_grant = cpu_valid && !dma_grant;
        end
    end

    assign cpu_ready = cpu_grant;
    assign dma_ready = dma_grant;

    // With no grant the CPU fields pass through but nothing is written.
    assign mem_req          = dma_grant ? dma_req : cpu_req;
    assign mem_addr         = mem_req.addr;
    assign mem_width        = 2'(mem_req.width);
    assign mem_sign_extend  = mem_req.sign_extend;
    assign mem_data_in      = mem_req.wdata;
    assign mem_write_enable = (cpu_grant || dma_grant) && mem_req.we;

    dmem_starve_counter #(
        .Limit (StarveLimit),
        .CntW  (StarveCntW)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .inc      (dma_valid && !dma_grant),
        .clr      (!dma_valid || dma_grant),
        .cnt      (starve_cnt),
        .at_limit (starve_at_limit)
    );

    // Remember who issued the load so its data is steered back next cycle.
    always_comb begin
        resp_owner_d = NONE;
        if (cpu_grant && !cpu_we) begin
            resp_owner_d = CPU;
        end else if (dma_grant && !dma_we) begin
            resp_owner_d = DMA;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_owner_q <= NONE;
        end else begin
            resp_owner_q <= resp_owner_d;
        end
    end

    assign cpu_rvalid = (resp_owner_q == CPU);
    assign dma_rvalid = (resp_owner_q == DMA);
    assign cpu_rdata  = mem_data_out;
    assign dma_rdata  = mem_data_out;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural one-cycle memory, vector table for
// grants/stores/loads, response scoreboard, and hand sequences for corners.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int unsigned Limit = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_valid, cpu_ready, cpu_sign_extend, cpu_we, cpu_rvalid;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [1:0]  cpu_width;
    logic        dma_valid, dma_ready, dma_sign_extend, dma_we, dma_rvalid;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic [1:0]  dma_width;
    logic [31:0] mem_addr, mem_data_in, mem_data_out;
    logic [1:0]  mem_width;
    logic        mem_sign_extend, mem_write_enable;

    dmem_arbiter #(.StarveLimit(Limit)) dut (
        .clk(clk), .reset(reset),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr),
        .cpu_width(cpu_width), .cpu_sign_extend(cpu_sign_extend), .cpu_we(cpu_we),
        .cpu_wdata(cpu_wdata), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_valid(dma_valid), .dma_ready(dma_ready), .dma_addr(dma_addr),
        .dma_width(dma_width), .dma_sign_extend(dma_sign_extend), .dma_we(dma_we),
        .dma_wdata(dma_wdata), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_width(mem_width), .mem_sign_extend(mem_sign_extend),
        .mem_write_enable(mem_write_enable), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Environment stand-in for the one-cycle-latency data memory.
    logic [7:0] mem_b [256];
    function automatic logic [31:0] env_read(input logic [7:0] a, input logic [1:0] w, input logic s);
        logic [31:0] r;
        r = {24'(0), mem_b[a]};
        if (w == BYTE && s) r = {{24{mem_b[a][7]}}, mem_b[a]};
        if (w == HALFWORD) r = {s ? {16{mem_b[8'(a+1)][7]}} : 16'(0), mem_b[8'(a+1)], mem_b[a]};
        if (w == WORD) r = {mem_b[8'(a+3)], mem_b[8'(a+2)], mem_b[8'(a+1)], mem_b[a]};
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_write_enable) begin
            mem_b[mem_addr[7:0]] <= mem_data_in[7:0];
            if (mem_width != BYTE) mem_b[8'(mem_addr[7:0] + 1)] <= mem_data_in[15:8];
            if (mem_width == WORD) begin
                mem_b[8'(mem_addr[7:0] + 2)] <= mem_data_in[23:16];
                mem_b[8'(mem_addr[7:0] + 3)] <= mem_data_in[31:24];
            end
        end else begin
            mem_data_out <= env_read(mem_addr[7:0], mem_width, mem_sign_extend);
        end
    end

    // Bench-side reference image, updated only from expected grants.
    logic [7:0] ref_b [256];
    function automatic logic [31:0] ref_read(input logic [7:0] a, input logic [1:0] w, input logic s);
        logic [31:0] r;
        case (w)
            BYTE:     r = s ? {{24{ref_b[a][7]}}, ref_b[a]} : {24'(0), ref_b[a]};
            HALFWORD: r = s ? {{16{ref_b[8'(a+1)][7]}}, ref_b[8'(a+1)], ref_b[a]}
                            : {16'(0), ref_b[8'(a+1)], ref_b[a]};
            default:  r = {ref_b[8'(a+3)], ref_b[8'(a+2)], ref_b[8'(a+1)], ref_b[a]};
        endcase
        return r;
    endfunction

    task automatic ref_write(input logic [7:0] a, input logic [1:0] w, input logic [31:0] d);
        ref_b[a] = d[7:0];
        if (w != BYTE) ref_b[8'(a+1)] = d[15:8];
        if (w == WORD) begin
            ref_b[8'(a+2)] = d[23:16];
            ref_b[8'(a+3)] = d[31:24];
        end
    endtask

    typedef struct {
        logic        is_dma;
        logic [31:0] data;
        int          due;
    } resp_t;
    resp_t exp_q[$];

    // Every negedge: either the due response appears on exactly its port, or no rvalid.
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            chk("rsp_cpu_rvalid", 32'(cpu_rvalid), 32'(!exp_q[0].is_dma));
            chk("rsp_dma_rvalid", 32'(dma_rvalid), 32'(exp_q[0].is_dma));
            chk("rsp_rdata", exp_q[0].is_dma ? dma_rdata : cpu_rdata, exp_q[0].data);
            void'(exp_q.pop_front());
        end else begin
            chk("idle_rvalid", 32'({cpu_rvalid, dma_rvalid}), 32'(0));
        end
    end

    typedef struct {
        logic cv; logic cwe; logic [31:0] ca; logic [1:0] cw; logic cs; logic [31:0] cd;
        logic dv; logic dwe; logic [31:0] da; logic [1:0] dw; logic ds; logic [31:0] dd;
        logic ecr; logic edr;
    } vec_t;

    int model_cnt = 0;

    task automatic run_vec(input vec_t v, input string nm);
        logic [31:0] exp_addr;
        cpu_valid = v.cv; cpu_we = v.cwe; cpu_addr = v.ca; cpu_width = v.cw;
        cpu_sign_extend = v.cs; cpu_wdata = v.cd;
        dma_valid = v.dv; dma_we = v.dwe; dma_addr = v.da; dma_width = v.dw;
        dma_sign_extend = v.ds; dma_wdata = v.dd;
        #1;
        exp_addr = v.edr ? v.da : v.ca;
        chk({nm, "_cpu_ready"}, 32'(cpu_ready), 32'(v.ecr));
        chk({nm, "_dma_ready"}, 32'(dma_ready), 32'(v.edr));
        chk({nm, "_mem_we"}, 32'(mem_write_enable), 32'((v.ecr && v.cwe) || (v.edr && v.dwe)));
        chk({nm, "_mem_addr"}, mem_addr, exp_addr);
        chk({nm, "_starve_cnt"}, 32'(dut.u_starve.cnt_q), 32'(model_cnt));
        if (v.ecr) begin
            if (v.cwe) ref_write(v.ca[7:0], v.cw, v.cd);
            else exp_q.push_back('{1'b0, ref_read(v.ca[7:0], v.cw, v.cs), cyc + 1});
        end
        if (v.edr) begin
            if (v.dwe) ref_write(v.da[7:0], v.dw, v.dd);
            else exp_q.push_back('{1'b1, ref_read(v.da[7:0], v.dw, v.ds), cyc + 1});
        end
        if (!v.dv || v.edr) model_cnt = 0;
        else if (model_cnt < int'(Limit)) model_cnt++;
        @(negedge clk);
    endtask

    function automatic vec_t both_loads(input logic ecr, input logic edr);
        vec_t v;
        v = '{1, 0, 32'h0, WORD, 0, 0, 1, 0, 32'h4, WORD, 0, 0, ecr, edr};
        return v;
    endfunction

    vec_t tbl [14];
    vec_t idle_v;
    vec_t v;
    logic [9:0] starve_pat;

    initial begin
        idle_v = '{0, 0, 32'h0, WORD, 0, 0, 0, 0, 32'h0, WORD, 0, 0, 0, 0};
        //        cv cwe  ca     cw       cs cd            dv dwe da     dw        ds dd          ecr edr
        tbl[0]  = '{1, 1, 32'h10, WORD,    0, 32'hDEADBEEF, 0, 0, 32'h0,  WORD,     0, 0,           1, 0};
        tbl[1]  = '{1, 0, 32'h10, WORD,    0, 0,            0, 0, 32'h0,  WORD,     0, 0,           1, 0};
        tbl[2]  = idle_v;
        tbl[3]  = '{0, 0, 32'h0,  WORD,    0, 0,            1, 1, 32'h21, BYTE,     0, 32'hA5,      0, 1};
        tbl[4]  = '{0, 0, 32'h0,  WORD,    0, 0,            1, 0, 32'h21, BYTE,     1, 0,           0, 1};
        tbl[5]  = '{1, 1, 32'h0,  WORD,    0, 32'h11223344, 1, 1, 32'h4,  WORD,     0, 32'h55667788, 1, 0};
        tbl[6]  = '{1, 1, 32'h8,  WORD,    0, 32'hCAFEF00D, 1, 1, 32'h4,  WORD,     0, 32'h55667788, 1, 0};
        tbl[7]  = '{0, 0, 32'h0,  WORD,    0, 0,            1, 1, 32'h4,  WORD,     0, 32'h55667788, 0, 1};
        tbl[8]  = '{1, 0, 32'h13, BYTE,    0, 0,            1, 0, 32'h12, HALFWORD, 1, 0,           1, 0};
        tbl[9]  = '{0, 0, 32'h0,  WORD,    0, 0,            1, 0, 32'h12, HALFWORD, 1, 0,           0, 1};
        tbl[10] = '{1, 0, 32'h0,  WORD,    0, 0,            0, 0, 32'h0,  WORD,     0, 0,           1, 0};
        tbl[11] = '{0, 0, 32'h0,  WORD,    0, 0,            1, 0, 32'h4,  WORD,     0, 0,           0, 1};
        tbl[12] = '{1, 0, 32'h8,  WORD,    0, 0,            0, 0, 32'h0,  WORD,     0, 0,           1, 0};
        tbl[13] = idle_v;

        // Reset with both masters requesting: nothing may be granted.
        reset = 1'b1;
        cpu_valid = 1; cpu_we = 1; cpu_addr = 32'h40; cpu_width = WORD;
        cpu_sign_extend = 0; cpu_wdata = 32'h0;
        dma_valid = 1; dma_we = 1; dma_addr = 32'h44; dma_width = WORD;
        dma_sign_extend = 0; dma_wdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_cpu_ready", 32'(cpu_ready), 32'(0));
        chk("rst_dma_ready", 32'(dma_ready), 32'(0));
        chk("rst_mem_we", 32'(mem_write_enable), 32'(0));
        chk("rst_starve_cnt", 32'(dut.u_starve.cnt_q), 32'(0));
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Continuous contention: four CPU grants, then one forced DMA grant.
        starve_pat = 10'b10000_10000;
        for (int i = 0; i < 10; i++) begin
            v = both_loads(!starve_pat[i], starve_pat[i]);
            run_vec(v, $sformatf("starve%0d", i));
        end
        run_vec(idle_v, "starve_idle");

        // DMA waits two cycles, drops, re-raises: counter restarts from zero.
        for (int i = 0; i < 2; i++) run_vec(both_loads(1, 0), $sformatf("drop_wait%0d", i));
        v = both_loads(1, 0);
        v.dv = 0;
        run_vec(v, "drop_gap");
        for (int i = 0; i < 4; i++) run_vec(both_loads(1, 0), $sformatf("drop_rerun%0d", i));
        run_vec(both_loads(0, 1), "drop_forced");
        run_vec(idle_v, "drop_idle");

        // Reset right after an accepted CPU load: its response is dropped.
        cpu_valid = 1; cpu_we = 0; cpu_addr = 32'h10; cpu_width = WORD;
        dma_valid = 0;
        #1;
        chk("rstmid_cpu_ready", 32'(cpu_ready), 32'(1));
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        dma_valid = 1;
        #1;
        chk("rstmid_cpu_ready_held", 32'(cpu_ready), 32'(0));
        chk("rstmid_dma_ready_held", 32'(dma_ready), 32'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_cnt = 0;
        cpu_valid = 0; dma_valid = 0;
        #1;
        chk("rstmid_starve_cnt", 32'(dut.u_starve.cnt_q), 32'(0));
        chk("rstmid_mem_we", 32'(mem_write_enable), 32'(0));
        @(negedge clk);
        v = tbl[1];
        run_vec(v, "post_rst_load");
        run_vec(idle_v, "final_idle");
        run_vec(idle_v, "final_idle2");

        chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
